// File: rtl/qsys_led_pio_blink.sv
// qsys_led_pio_blink: Avalon-MM output PIO with atomic set/clear and a per-bit blink engine
module qsys_led_pio_blink #(
  parameter int          WIDTH        = 10,
  parameter logic [31:0] RESET_VALUE  = 32'h255,
  parameter logic [31:0] RESET_MASK   = 32'h0,
  parameter int          PERIOD_W     = 26,
  parameter logic [31:0] RESET_PERIOD = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0]    data, mask, wd;
  logic [PERIOD_W-1:0] period, cnt;
  logic                phase, we, restart, unused_wd;
  assign we        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  // PERIOD and STATUS writes both restart the prescaler, winning over a terminal count
  assign restart   = we & (address == 3'd2 | address == 3'd3);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_VALUE[WIDTH-1:0];
      mask   <= RESET_MASK[WIDTH-1:0];
      period <= RESET_PERIOD[PERIOD_W-1:0];
      cnt    <= '0;
      phase  <= 1'b0;
    end else begin
      if (we) begin
        data <= (address == 3'd0) ? wd :
                (address == 3'd4) ? (data | wd) :
                (address == 3'd5) ? (data & ~wd) : data;
        if (address == 3'd1) mask <= wd;
        if (address == 3'd2) period <= writedata[PERIOD_W-1:0];
      end
      if (restart || period == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == period) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign readdata = (address == 3'd0) ? 32'(data) :
                    (address == 3'd1) ? 32'(mask) :
                    (address == 3'd2) ? 32'(period) :
                    (address == 3'd3) ? {31'd0, phase} : 32'd0;
  assign out_port = data & ~(mask & {WIDTH{phase}});
endmodule
